// File: rtl/sram_ctrl_param.sv
// Controller for a 16-bit asynchronous SRAM. Each DATA_W-bit host access is split into
// DATA_W/16 halfword beats, each lasting WAIT_CYCLES+1 cycles.
module sram_ctrl_param #(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic                busy,
    output logic                ready,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    localparam int BYTES      = DATA_W / 8;
    localparam int BEATS      = DATA_W / 16;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_SHIFT = $clog2(BYTES);
    localparam int WAIT_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [31:0]         word_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BYTES-1:0]    ben_q;
    logic                rd_op_q;
    logic [DATA_W-1:0]   shadow;
    logic                xfer;
    logic                beat_end;
    logic                last_beat;
    logic                accept;
    logic                dq_oe;
    logic [15:0]         dq_out;

    assign xfer      = (state == S_WRITE) || (state == S_READ);
    assign beat_end  = (wait_cnt == WAIT_W'(WAIT_CYCLES));
    assign last_beat = beat_end && (beat_cnt == BEAT_W'(BEATS - 1));
    assign accept    = (state == S_IDLE) && (wr_en || rd_en);

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_en)      state_nxt = S_WRITE;
                else if (rd_en) state_nxt = S_READ;
            end
            S_WRITE, S_READ: if (last_beat) state_nxt = S_RECOVER;
            S_RECOVER:       state_nxt = S_DONE;
            S_DONE:          state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // Wait counter runs inside a beat; the beat counter steps when it wraps.
    always_ff @(posedge clk) begin
        if (rst || !xfer) begin
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else if (beat_end) begin
            wait_cnt <= '0;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // NOTE: request and shadow registers carry no reset; they are always loaded
    // before being used, so resetting them would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= address >> WORD_SHIFT;
            wdata_q <= write_data;
            ben_q   <= byte_en;
            rd_op_q <= !wr_en;
        end
        if (state == S_READ && beat_end)
            shadow[{beat_cnt, 4'b0000} +: 16] <= SRAM_DQ;
    end

    always_ff @(posedge clk) begin
        if (rst)
            read_data <= '0;
        else if (state == S_RECOVER && rd_op_q)
            read_data <= shadow;
    end

    // Strobes depend only on registered state; busy alone looks at the request inputs.
    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        busy      = 1'b0;
        ready     = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[{beat_cnt, 4'b0000} +: 16];
        case (state)
            S_IDLE: busy = wr_en || rd_en;
            S_WRITE: begin
                busy      = 1'b1;
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                SRAM_LB_N = ~ben_q[{beat_cnt, 1'b0}];
                SRAM_UB_N = ~ben_q[{beat_cnt, 1'b1}];
                SRAM_ADDR = SRAM_AW'(word_q * 32'(BEATS) + 32'(beat_cnt));
                dq_oe     = 1'b1;
            end
            S_READ: begin
                busy      = 1'b1;
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_ADDR = SRAM_AW'(word_q * 32'(BEATS) + 32'(beat_cnt));
            end
            S_RECOVER: busy = 1'b1;
            S_DONE:    ready = 1'b1;
            default:   ;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: a 32-bit/no-wait instance and a 64-bit/2-wait instance,
// each with a behavioural SRAM and a cycle-level reference model.
module tb_sram_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic        wr    [2];
    logic        rd    [2];
    logic [31:0] addr  [2];
    logic [63:0] wdata [2];
    logic [7:0]  ben   [2];

    logic [31:0] a_rdata;
    logic        a_busy, a_ready, a_we, a_oe, a_ce, a_ub, a_lb;
    logic [9:0]  a_sa;
    wire  [15:0] a_dq;
    logic [63:0] b_rdata;
    logic        b_busy, b_ready, b_we, b_oe, b_ce, b_ub, b_lb;
    logic [7:0]  b_sa;
    wire  [15:0] b_dq;

    sram_ctrl_param #(.DATA_W(32), .WAIT_CYCLES(0), .SRAM_AW(10)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr[0]), .rd_en(rd[0]), .address(addr[0]),
        .write_data(wdata[0][31:0]), .byte_en(ben[0][3:0]), .read_data(a_rdata),
        .busy(a_busy), .ready(a_ready), .SRAM_DQ(a_dq), .SRAM_ADDR(a_sa),
        .SRAM_WE_N(a_we), .SRAM_OE_N(a_oe), .SRAM_CE_N(a_ce), .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb)
    );

    sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(2), .SRAM_AW(8)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr[1]), .rd_en(rd[1]), .address(addr[1]),
        .write_data(wdata[1]), .byte_en(ben[1]), .read_data(b_rdata),
        .busy(b_busy), .ready(b_ready), .SRAM_DQ(b_dq), .SRAM_ADDR(b_sa),
        .SRAM_WE_N(b_we), .SRAM_OE_N(b_oe), .SRAM_CE_N(b_ce), .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb)
    );

    // Asynchronous SRAM models: drive on OE, store enabled bytes while WE is low.
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [256];

    assign a_dq = (!a_ce && !a_oe && a_we) ? mem_a[a_sa] : 16'bz;
    assign b_dq = (!b_ce && !b_oe && b_we) ? mem_b[b_sa] : 16'bz;

    always @(negedge clk) begin
        if (!a_ce && !a_we) begin
            if (!a_lb) mem_a[a_sa][7:0]  <= a_dq[7:0];
            if (!a_ub) mem_a[a_sa][15:8] <= a_dq[15:8];
        end
        if (!b_ce && !b_we) begin
            if (!b_lb) mem_b[b_sa][7:0]  <= b_dq[7:0];
            if (!b_ub) mem_b[b_sa][15:8] <= b_dq[15:8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: m_t is the cycle number within the current access
    // (1..N beats, N+1 turnaround, N+2 completion), -1 when idle.
    int          m_t     [2];
    logic        m_wr    [2];
    logic [31:0] m_word  [2];
    logic [63:0] m_wdata [2];
    logic [7:0]  m_ben   [2];
    logic [63:0] m_rdata [2];

    function automatic int beats_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int per_beat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int sram_index(input int i, input logic [31:0] word, input int b);
        int aw = (i == 0) ? 10 : 8;
        return int'((word * 32'(beats_of(i)) + 32'(b)) % (32'd1 << aw));
    endfunction

    function automatic logic [63:0] sram_word(input int i);
        logic [63:0] r = '0;
        for (int b = 0; b < beats_of(i); b++) begin
            int idx = sram_index(i, m_word[i], b);
            r[16*b +: 16] = (i == 0) ? mem_a[idx] : mem_b[idx];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i]     <= -1;
                m_rdata[i] <= '0;
            end else if (m_t[i] < 0) begin
                if (wr[i] || rd[i]) begin
                    m_t[i]     <= 1;
                    m_wr[i]    <= wr[i];
                    m_word[i]  <= addr[i] >> ((i == 0) ? 2 : 3);
                    m_wdata[i] <= wdata[i];
                    m_ben[i]   <= ben[i];
                end
            end else if (m_t[i] >= beats_of(i) * per_beat(i) + 2) begin
                m_t[i] <= -1;
            end else begin
                m_t[i] <= m_t[i] + 1;
                if (m_t[i] == beats_of(i) * per_beat(i) + 1 && !m_wr[i])
                    m_rdata[i] <= sram_word(i);
            end
        end
    end

    task automatic cmp_cycle(input int i, input logic [63:0] rdat, input logic busy_o,
                             input logic ready_o, input logic [4:0] strb,
                             input logic [31:0] sa, input logic [15:0] dq);
        string       p = (i == 0) ? "a" : "b";
        int          t = m_t[i];
        int          n = beats_of(i) * per_beat(i);
        logic        e_busy = 1'b0;
        logic        e_ready = 1'b0;
        logic [4:0]  e_strb = 5'b11111;   // {we, oe, ce, ub, lb}
        logic [31:0] e_sa = '0;
        if (t < 0) begin
            e_busy = wr[i] | rd[i];
        end else if (t <= n) begin
            int b = (t - 1) / per_beat(i);
            e_busy = 1'b1;
            e_sa   = 32'(sram_index(i, m_word[i], b));
            if (m_wr[i]) begin
                e_strb = {1'b0, 1'b1, 1'b0, ~m_ben[i][2*b+1], ~m_ben[i][2*b]};
                check({p, ".dq"}, 64'(dq), 64'(m_wdata[i][16*b +: 16]));
            end else begin
                e_strb = 5'b10000;
            end
        end else if (t == n + 1) begin
            e_busy = 1'b1;
        end else begin
            e_ready = 1'b1;
        end
        check({p, ".busy"}, 64'(busy_o), 64'(e_busy));
        check({p, ".ready"}, 64'(ready_o), 64'(e_ready));
        check({p, ".strobes"}, 64'(strb), 64'(e_strb));
        check({p, ".sram_addr"}, 64'(sa), 64'(e_sa));
        check({p, ".read_data"}, rdat, m_rdata[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_cycle(0, 64'(a_rdata), a_busy, a_ready, {a_we, a_oe, a_ce, a_ub, a_lb},
                      32'(a_sa), a_dq);
            cmp_cycle(1, b_rdata, b_busy, b_ready, {b_we, b_oe, b_ce, b_ub, b_lb},
                      32'(b_sa), b_dq);
        end
    end

    // Per-cycle snapshots of the last access, indexed by cycle number (0 = request cycle).
    logic [31:0] s_sa    [40];
    logic [15:0] s_dq    [40];
    logic [4:0]  s_strb  [40];
    logic        s_busy  [40];

    task automatic access(input int i, input bit w, input bit r, input logic [31:0] a,
                          input logic [63:0] d, input logic [7:0] be, output int done_cyc);
        logic rdy;
        @(posedge clk);
        #1;
        wr[i] = w; rd[i] = r; addr[i] = a; wdata[i] = d; ben[i] = be;
        done_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            s_sa[k]   = (i == 0) ? 32'(a_sa) : 32'(b_sa);
            s_dq[k]   = (i == 0) ? a_dq : b_dq;
            s_strb[k] = (i == 0) ? {a_we, a_oe, a_ce, a_ub, a_lb} : {b_we, b_oe, b_ce, b_ub, b_lb};
            s_busy[k] = (i == 0) ? a_busy : b_busy;
            rdy       = (i == 0) ? a_ready : b_ready;
            if (k == 1) begin
                addr[i] = ~a; wdata[i] = ~d; ben[i] = ~be;
            end
            if (rdy) begin
                done_cyc = k;
                break;
            end
        end
        wr[i] = 1'b0;
        rd[i] = 1'b0;
        check("ready_seen", 64'(done_cyc >= 0), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int dc;
        for (int i = 0; i < 2; i++) begin
            wr[i] = 1'b0; rd[i] = 1'b0; addr[i] = '0; wdata[i] = '0; ben[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst.read_data", 64'(a_rdata), 64'd0);
        check("rst.busy", 64'(a_busy), 64'd0);
        check("rst.ready", 64'(a_ready), 64'd0);
        check("rst.strobes", 64'({a_we, a_oe, a_ce, a_ub, a_lb}), 64'h1f);
        check("rst.sram_addr", 64'(a_sa), 64'd0);

        // 32-bit write, all bytes
        access(0, 1'b1, 1'b0, 32'h104, 64'hDEADBEEF, 8'hF, dc);
        check("w32.latency", 64'(dc), 64'd4);
        check("w32.addr_c1", 64'(s_sa[1]), 64'h82);
        check("w32.dq_c1", 64'(s_dq[1]), 64'hBEEF);
        check("w32.addr_c2", 64'(s_sa[2]), 64'h83);
        check("w32.dq_c2", 64'(s_dq[2]), 64'hDEAD);
        check("w32.busy_c3", 64'(s_busy[3]), 64'd1);
        check("w32.busy_c4", 64'(s_busy[4]), 64'd0);
        check("w32.mem_lo", 64'(mem_a[10'h82]), 64'hBEEF);
        check("w32.mem_hi", 64'(mem_a[10'h83]), 64'hDEAD);

        // Reset during cycle 2 of a write
        @(posedge clk);
        #1;
        wr[0] = 1'b1; addr[0] = 32'h200; wdata[0] = 64'h11223344; ben[0] = 8'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; wr[0] = 1'b0;
        @(negedge clk);
        check("rstmid.we_c2", 64'(a_we), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.we_c3", 64'(a_we), 64'd1);
        check("rstmid.ce_c3", 64'(a_ce), 64'd1);
        check("rstmid.oe_c3", 64'(a_oe), 64'd1);
        check("rstmid.busy_c3", 64'(a_busy), 64'd0);
        check("rstmid.read_data", 64'(a_rdata), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rstmid.no_ready", 64'(a_ready), 64'd0);
        end

        // 32-bit read of the first write
        access(0, 1'b0, 1'b1, 32'h104, 64'h0, 8'h0, dc);
        check("r32.latency", 64'(dc), 64'd4);
        check("r32.strobes_c1", 64'(s_strb[1]), 64'h10);
        check("r32.read_data", 64'(a_rdata), 64'hDEADBEEF);

        // Byte-enable write touching only byte 1
        access(0, 1'b1, 1'b0, 32'h104, 64'h55667788, 8'b0010, dc);
        check("be.strobes_b0", 64'(s_strb[1]), 64'b01001);
        check("be.strobes_b1", 64'(s_strb[2]), 64'b01011);
        check("be.mem_lo", 64'(mem_a[10'h82]), 64'h77EF);
        check("be.mem_hi", 64'(mem_a[10'h83]), 64'hDEAD);

        // Write and read together: write wins, single completion
        access(0, 1'b1, 1'b1, 32'h300, 64'hCAFEF00D, 8'hF, dc);
        check("both.latency", 64'(dc), 64'd4);
        check("both.we_c1", 64'(s_strb[1][4]), 64'd0);
        check("both.mem", 64'(mem_a[10'h180]), 64'hF00D);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("both.single_ready", 64'(a_ready), 64'd0);
        end
        check("both.read_data_held", 64'(a_rdata), 64'hDEADBEEF);

        // 64-bit, two wait states
        access(1, 1'b1, 1'b0, 32'h100, 64'hCDEF89AB45670123, 8'hFF, dc);
        check("w64.latency", 64'(dc), 64'd14);
        check("w64.dq_c1", 64'(s_dq[1]), 64'h0123);
        access(1, 1'b0, 1'b1, 32'h100, 64'h0, 8'h0, dc);
        check("r64.latency", 64'(dc), 64'd14);
        check("r64.addr_c1", 64'(s_sa[1]), 64'h80);
        check("r64.addr_c3", 64'(s_sa[3]), 64'h80);
        check("r64.addr_c4", 64'(s_sa[4]), 64'h81);
        check("r64.addr_c12", 64'(s_sa[12]), 64'h83);
        check("r64.busy_c13", 64'(s_busy[13]), 64'd1);
        check("r64.read_data", b_rdata, 64'hCDEF89AB45670123);

        // Word address beyond the SRAM wraps to 0
        access(1, 1'b1, 1'b0, 32'h200, 64'h0A0B0C0D01020304, 8'hFF, dc);
        check("wrap.addr_c1", 64'(s_sa[1]), 64'h00);
        check("wrap.addr_c10", 64'(s_sa[10]), 64'h03);
        access(1, 1'b0, 1'b1, 32'h200, 64'h0, 8'h0, dc);
        check("wrap.read_data", b_rdata, 64'h0A0B0C0D01020304);
        check("wrap.a_read_data_held", 64'(a_rdata), 64'hDEADBEEF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
